// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit unsigned adder that reuses a single 4-bit
// carry-select slice for N = WIDTH/4 clock cycles. The least-significant
// nibble goes first, and the carry between nibbles is held in a register.
// There is a valid/ready handshake on the operand side and on the result side.

// carry_select: 4-bit adder slice. The low two bits ripple. The high two bits
// are computed twice, once for each possible carry, and the low carry picks one.
module carry_select (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [2:0] lo_sum;
  logic [2:0] hi_sum0;
  logic [2:0] hi_sum1;
  logic [2:0] hi_sel;

  // Low pair ripples from the carry-in; high pair is speculated for both carries
  always_comb begin
    lo_sum  = {1'b0, a_i[1:0]} + {1'b0, b_i[1:0]} + {2'b00, c_i};
    hi_sum0 = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]};
    hi_sum1 = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]} + 3'd1;
    hi_sel  = lo_sum[2] ? hi_sum1 : hi_sum0;
    sum_o   = {hi_sel[1:0], lo_sum[1:0]};
    cout_o  = hi_sel[2];
  end

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  // Select the nibble of each stored operand that the current step works on
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  carry_select u_slice (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .c_i    (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Next-state and datapath update. Every register holds its value unless this step writes it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[4*i +: 4] = slice_sum;
          end
        end
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. A reset drops any operation in flight and clears the datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake outputs decode from the state alone, so no input reaches them combinationally
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder. It uses a WIDTH=16
// instance and a WIDTH=4 instance.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [15:0] a, b, sum;

  logic        iv4, ir4, ov4, or4, cin4, co4;
  logic [3:0]  a4, b4, s4;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (ov4),
    .out_ready (or4),
    .sum       (s4),
    .cout      (co4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge, then scramble them so only the edge values matter
  task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic c);
    a = av; b = bv; cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
  endtask

  // Count the edges after the accept until out_valid is seen; -1 if it never rises
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    int lat;
    rst_n = 1'b0;
    tick(); tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (sum !== 16'h0000) $display("FAIL rst_sum got=%h exp=0000", sum); else pass_cnt++;
    total_cnt++; if (cout !== 1'b0) $display("FAIL rst_cout got=%b exp=0", cout); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    // start an operation, then reset it two edges into RUN
    accept(16'h5A5A, 16'hA5A5, 1'b1);
    tick();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL run_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (sum !== 16'h0000) $display("FAIL midrst_sum got=%h exp=0000", sum); else pass_cnt++;
    total_cnt++; if (cout !== 1'b0) $display("FAIL midrst_cout got=%b exp=0", cout); else pass_cnt++;
    accept(16'h0001, 16'h0001, 1'b0);
    wait_done(lat);
    total_cnt++; if (sum !== 16'h0002) $display("FAIL postrst_sum got=%h exp=0002", sum); else pass_cnt++;
    total_cnt++; if (cout !== 1'b0) $display("FAIL postrst_cout got=%b exp=0", cout); else pass_cnt++;
    consume();
  endtask

  task automatic test_basic_add;
    int lat;
    accept(16'h1234, 16'h4321, 1'b0);
    wait_done(lat);
    total_cnt++; if (lat !== 4) $display("FAIL basic_latency got=%0d exp=4", lat); else pass_cnt++;
    total_cnt++; if (sum !== 16'h5555) $display("FAIL basic_sum got=%h exp=5555", sum); else pass_cnt++;
    total_cnt++; if (cout !== 1'b0) $display("FAIL basic_cout got=%b exp=0", cout); else pass_cnt++;
    consume();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_ready_after got=%b exp=1", in_ready); else pass_cnt++;
  endtask

  task automatic test_full_ripple;
    int lat;
    accept(16'hFFFF, 16'h0000, 1'b1);
    wait_done(lat);
    total_cnt++; if (lat !== 4) $display("FAIL ripple_latency got=%0d exp=4", lat); else pass_cnt++;
    total_cnt++; if (sum !== 16'h0000) $display("FAIL ripple_sum got=%h exp=0000", sum); else pass_cnt++;
    total_cnt++; if (cout !== 1'b1) $display("FAIL ripple_cout got=%b exp=1", cout); else pass_cnt++;
    consume();
  endtask

  task automatic test_backpressure;
    int lat;
    accept(16'h8000, 16'h8000, 1'b0);
    wait_done(lat);
    total_cnt++; if (lat !== 4) $display("FAIL bp_latency got=%0d exp=4", lat); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      a = 16'h1111; b = 16'h2222; cin = 1'b1;
      in_valid = k[0];
      tick();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d] got=%b exp=1", k, out_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, in_ready); else pass_cnt++;
      total_cnt++; if ({cout, sum} !== 17'h10000) $display("FAIL bp_result[%0d] got=%b/%h exp=1/0000", k, cout, sum); else pass_cnt++;
    end
    in_valid = 1'b0;
    consume();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after got=%b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_valid_after got=%b exp=0", out_valid); else pass_cnt++;
    tick();
    // with no accept, IDLE keeps the last result and the block stays ready
    total_cnt++; if ({in_ready, cout, sum} !== 18'h30000) $display("FAIL bp_idle_hold got=%b/%b/%h exp=1/1/0000", in_ready, cout, sum); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int edge_n = 0;
    int nacc = 0;
    int nres = 0;
    int acc_e[2];
    logic [15:0] rs[2];
    logic        rc[2];
    logic        fire_in, fire_out;
    logic [15:0] s_cap;
    logic        c_cap;
    acc_e[0] = 0; acc_e[1] = 0;
    rs[0] = 'x; rs[1] = 'x; rc[0] = 1'bx; rc[1] = 1'bx;
    a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 40 && nres < 2; k++) begin
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      s_cap = sum; c_cap = cout;
      tick();
      edge_n++;
      if (fire_in && nacc < 2) begin
        acc_e[nacc] = edge_n;
        nacc++;
        if (nacc == 1) begin
          a = 16'hABCD; b = 16'h1111; cin = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (fire_out && nres < 2) begin
        rs[nres] = s_cap;
        rc[nres] = c_cap;
        nres++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++; if (nres !== 2) $display("FAIL b2b_results got=%0d exp=2", nres); else pass_cnt++;
    total_cnt++; if (acc_e[1] - acc_e[0] !== 6) $display("FAIL b2b_interval got=%0d exp=6", acc_e[1] - acc_e[0]); else pass_cnt++;
    total_cnt++; if ({rc[0], rs[0]} !== 17'h00100) $display("FAIL b2b_first got=%b/%h exp=0/0100", rc[0], rs[0]); else pass_cnt++;
    total_cnt++; if ({rc[1], rs[1]} !== 17'h0BCDF) $display("FAIL b2b_second got=%b/%h exp=0/bcdf", rc[1], rs[1]); else pass_cnt++;
  endtask

  task automatic test_min_width;
    a4 = 4'h9; b4 = 4'h7; cin4 = 1'b0; iv4 = 1'b1;
    tick();
    iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    total_cnt++; if (ir4 !== 1'b0) $display("FAIL w4_in_ready_run got=%b exp=0", ir4); else pass_cnt++;
    total_cnt++; if (ov4 !== 1'b0) $display("FAIL w4_valid_early got=%b exp=0", ov4); else pass_cnt++;
    tick();
    total_cnt++; if (ov4 !== 1'b1) $display("FAIL w4_out_valid got=%b exp=1", ov4); else pass_cnt++;
    total_cnt++; if (s4 !== 4'h0) $display("FAIL w4_sum got=%h exp=0", s4); else pass_cnt++;
    total_cnt++; if (co4 !== 1'b1) $display("FAIL w4_cout got=%b exp=1", co4); else pass_cnt++;
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    total_cnt++; if (ir4 !== 1'b1) $display("FAIL w4_ready_after got=%b exp=1", ir4); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    test_reset();
    test_basic_add();
    test_full_ripple();
    test_backpressure();
    test_back_to_back();
    test_min_width();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
